pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 27 ++
 rtl/pll_lock_supervisor_if.sv | 24 ++
 rtl/sync_2ff.sv | 19 +
 rtl/pll_lock_supervisor.sv | 135 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared types, defaults and sizing helpers for the PLL lock supervisor
package pll_sup_pkg;

   typedef enum logic [2:0] {
      S_RESET,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAIL
   } state_t;

   localparam int DEF_RST_PULSE_CYC   = 16;
   localparam int DEF_LOCK_TIMEOUT_CYC = 27000;
   localparam int DEF_STABLE_CYC      = 1024;
   localparam int DEF_MAX_RETRY       = 7;
   localparam int DEF_DROP_FILTER_CYC = 4;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - PLL-side and system-side signals of the lock supervisor
interface pll_lock_supervisor_if
   import pll_sup_pkg::*;
#(
   parameter int RETRY_W = cnt_width(DEF_MAX_RETRY)
);
   logic               pll_lock;
   logic               pll_reset;
   logic               sys_rst_n;
   logic               pll_ready;
   logic               fail;
   logic [RETRY_W-1:0] retry_cnt;
   logic [7:0]         lock_lost_cnt;

   modport master (
      input  pll_lock,
      output pll_reset, sys_rst_n, pll_ready, fail, retry_cnt, lock_lost_cnt
   );

   modport slave (
      output pll_lock,
      input  pll_reset, sys_rst_n, pll_ready, fail, retry_cnt, lock_lost_cnt
   );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchronizer for asynchronous status inputs
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - sequences PLL reset, lock qualification and downstream reset release
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
   parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
   parameter int STABLE_CYC       = DEF_STABLE_CYC,
   parameter int MAX_RETRY        = DEF_MAX_RETRY,
   parameter int DROP_FILTER_CYC  = DEF_DROP_FILTER_CYC
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pll_lock_supervisor_if.master  bus
);
   localparam int RETRY_W = cnt_width(MAX_RETRY);
   // One shared cycle counter serves every timed state; size it for the longest interval.
   localparam int CW = cnt_width(max_int(max_int(RST_PULSE_CYC, LOCK_TIMEOUT_CYC),
                                         max_int(STABLE_CYC, DROP_FILTER_CYC)));

   localparam logic [CW-1:0]      RST_LAST     = CW'(RST_PULSE_CYC - 1);
   localparam logic [CW-1:0]      TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CW-1:0]      STABLE_LAST  = CW'(STABLE_CYC - 1);
   localparam logic [CW-1:0]      DROP_LAST    = CW'(DROP_FILTER_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic [RETRY_W-1:0] retry_q, retry_nxt;
   logic [7:0]         lost_q, lost_nxt;
   logic               pll_reset_q, sys_rst_n_q, pll_ready_q, fail_q;
   logic               lock_s;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.pll_lock),
      .q     (lock_s)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_RESET;
         cnt         <= '0;
         retry_q     <= '0;
         lost_q      <= '0;
         pll_reset_q <= 1'b1;
         sys_rst_n_q <= 1'b0;
         pll_ready_q <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         retry_q     <= retry_nxt;
         lost_q      <= lost_nxt;
         // Outputs follow the state being entered so they change on the transition edge.
         pll_reset_q <= (state_nxt == S_RESET) || (state_nxt == S_FAIL);
         sys_rst_n_q <= (state_nxt == S_RUN);
         pll_ready_q <= (state_nxt == S_RUN);
         fail_q      <= (state_nxt == S_FAIL);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = retry_q;
      lost_nxt  = lost_q;
      unique case (state)
         S_RESET: begin
            if (cnt == RST_LAST) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_WAIT_LOCK: begin
            // Lock is checked before the timeout so a coincident lock still wins.
            if (lock_s) begin
               state_nxt = S_STABLE;
               cnt_nxt   = CW'(1);
            end else if (cnt == TIMEOUT_LAST) begin
               cnt_nxt = '0;
               if (retry_q == RETRY_MAX) begin
                  state_nxt = S_FAIL;
               end else begin
                  state_nxt = S_RESET;
                  retry_nxt = retry_q + RETRY_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_STABLE: begin
            if (!lock_s) begin
               state_nxt = S_WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt == STABLE_LAST) begin
               state_nxt = S_RUN;
               cnt_nxt   = '0;
               retry_nxt = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_RUN: begin
            if (lock_s) begin
               cnt_nxt = '0;
            end else if (cnt == DROP_LAST) begin
               state_nxt = S_RESET;
               cnt_nxt   = '0;
               if (lost_q != 8'hFF) begin
                  lost_nxt = lost_q + 8'd1;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_FAIL: begin
            state_nxt = S_FAIL;
         end
         default: begin
            state_nxt = S_RESET;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign bus.pll_reset     = pll_reset_q;
   assign bus.sys_rst_n     = sys_rst_n_q;
   assign bus.pll_ready     = pll_ready_q;
   assign bus.fail          = fail_q;
   assign bus.retry_cnt     = retry_q;
   assign bus.lock_lost_cnt = lost_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - randomized and directed bench for pll_lock_supervisor
module tb_pll_lock_supervisor;
   localparam int RST_PULSE = 4;
   localparam int TIMEOUT   = 20;
   localparam int STABLE    = 8;
   localparam int MAXR      = 2;
   localparam int DROP      = 3;

   localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_FAIL = 4;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   pll_lock_supervisor_if #(.RETRY_W(2)) bus ();

   pll_lock_supervisor #(
      .RST_PULSE_CYC    (RST_PULSE),
      .LOCK_TIMEOUT_CYC (TIMEOUT),
      .STABLE_CYC       (STABLE),
      .MAX_RETRY        (MAXR),
      .DROP_FILTER_CYC  (DROP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: phase plus time-in-phase, with lock seen two samples late.
   bit m_valid = 0;
   int m_phase, m_t, m_highs, m_low, m_retry, m_lost;
   bit d1, d2, ls;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1;
         m_phase = P_RST;
         m_t = 0; m_highs = 0; m_low = 0; m_retry = 0; m_lost = 0;
         d1 = 0; d2 = 0;
      end else begin
         ls = d2;
         d2 = d1;
         d1 = bus.pll_lock;
         case (m_phase)
            P_RST: begin
               m_t++;
               if (m_t == RST_PULSE) begin m_phase = P_WAIT; m_t = 0; end
            end
            P_WAIT: begin
               if (ls) begin
                  m_phase = P_STB; m_highs = 1;
               end else begin
                  m_t++;
                  if (m_t == TIMEOUT) begin
                     if (m_retry < MAXR) begin m_retry++; m_phase = P_RST; m_t = 0; end
                     else m_phase = P_FAIL;
                  end
               end
            end
            P_STB: begin
               if (!ls) begin
                  m_phase = P_WAIT; m_t = 0;
               end else begin
                  m_highs++;
                  if (m_highs == STABLE) begin m_phase = P_RUN; m_retry = 0; m_low = 0; end
               end
            end
            P_RUN: begin
               m_low = ls ? 0 : m_low + 1;
               if (m_low == DROP) begin
                  if (m_lost < 255) m_lost++;
                  m_phase = P_RST; m_t = 0;
               end
            end
            default: ;
         endcase
      end
   end

   function automatic logic [31:0] exp_vec();
      logic in_run;
      in_run = (m_phase == P_RUN);
      return {18'd0, (m_phase == P_RST) || (m_phase == P_FAIL), in_run, in_run,
              m_phase == P_FAIL, 2'(m_retry), 8'(m_lost)};
   endfunction

   function automatic logic [31:0] dut_vec();
      return {18'd0, bus.pll_reset, bus.sys_rst_n, bus.pll_ready, bus.fail,
              bus.retry_cnt, bus.lock_lost_cnt};
   endfunction

   always @(negedge clk) begin
      if (m_valid) check_eq("cycle_model", dut_vec(), exp_vec());
   end

   task automatic wait_ready(input int budget);
      int n = 0;
      while (!bus.pll_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("wait_ready", 32'(bus.pll_ready), 32'd1);
   endtask

   task automatic wait_unready(input int budget);
      int n = 0;
      while (bus.pll_ready && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("wait_unready", 32'(bus.pll_ready), 32'd0);
   endtask

   initial begin
      int n, rises;
      bit prev;

      // Clean lock
      rst_n = 1'b0;
      bus.pll_lock = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset_vec", dut_vec(), 32'h2000);
      rst_n = 1'b1;
      n = 0;
      while (bus.pll_reset && n < 50) begin n++; @(negedge clk); end
      check_eq("rst_pulse_len", n, RST_PULSE);
      repeat (5) @(negedge clk);
      bus.pll_lock = 1'b1;
      n = 0;
      while (!bus.pll_ready && n < 100) begin @(negedge clk); n++; end
      check_eq("release_latency", n, STABLE + 2);
      check_eq("release_sys_rst_n", 32'(bus.sys_rst_n), 1);
      check_eq("release_retry", 32'(bus.retry_cnt), 0);
      check_eq("release_fail", 32'(bus.fail), 0);

      // Glitch filter
      repeat (3) @(negedge clk);
      bus.pll_lock = 1'b0;
      repeat (DROP - 1) @(negedge clk);
      bus.pll_lock = 1'b1;
      repeat (6) @(negedge clk);
      check_eq("glitch_ignored", 32'(bus.pll_ready), 1);
      check_eq("glitch_lost", 32'(bus.lock_lost_cnt), 0);
      bus.pll_lock = 1'b0;
      n = 0;
      while (bus.sys_rst_n && n < 20) begin @(negedge clk); n++; end
      check_eq("drop_latency", n, DROP + 2);
      check_eq("drop_lost", 32'(bus.lock_lost_cnt), 1);
      check_eq("drop_pll_reset", 32'(bus.pll_reset), 1);
      bus.pll_lock = 1'b1;
      wait_ready(100);

      // rst_n mid-RUN
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("midrun_reset_vec", dut_vec(), 32'h2000);
      wait_ready(100);

      // Never lock
      bus.pll_lock = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rises = 0;
      prev = 1'b0;
      for (int i = 0; i < 3 * (RST_PULSE + TIMEOUT) + 15; i++) begin
         if (bus.pll_reset && !prev) rises++;
         prev = bus.pll_reset;
         @(negedge clk);
      end
      // three reset pulses, then the permanent assertion on entering failure
      check_eq("nolock_rises", rises, 4);
      check_eq("nolock_fail", 32'(bus.fail), 1);
      check_eq("nolock_pll_reset", 32'(bus.pll_reset), 1);
      check_eq("nolock_sys_rst_n", 32'(bus.sys_rst_n), 0);
      check_eq("nolock_retry", 32'(bus.retry_cnt), MAXR);

      // Drop during stable qualification
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (bus.pll_reset && n < 50) begin n++; @(negedge clk); end
      repeat (3) @(negedge clk);
      bus.pll_lock = 1'b1;
      repeat (5) @(negedge clk);
      bus.pll_lock = 1'b0;
      @(negedge clk);
      bus.pll_lock = 1'b1;
      n = 0;
      rises = 0;
      while (!bus.pll_ready && n < 100) begin
         @(negedge clk);
         n++;
         if (bus.pll_reset) rises++;
      end
      check_eq("stable_drop_latency", n, STABLE + 2);
      check_eq("stable_drop_no_pulse", rises, 0);

      // Counter saturation
      for (int i = 0; i < 260; i++) begin
         wait_ready(100);
         bus.pll_lock = 1'b0;
         wait_unready(20);
         bus.pll_lock = 1'b1;
      end
      wait_ready(100);
      check_eq("lost_saturated", 32'(bus.lock_lost_cnt), 255);

      // Random lock activity with occasional resets
      for (int i = 0; i < 120; i++) begin
         bus.pll_lock = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         repeat ($urandom_range(1, 30)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
